fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
//
// PURPOSE
//   Instruction queue between the fetch stage (PC + instruction memory) and
//   decode. Buffers {pc, instruction} pairs from fetch in order and presents
//   them to decode over a valid/ready handshake. Absorbs decode stalls
//   without stopping the PC on every cycle. Flush discards all buffered
//   (wrong-path) instructions when a branch is taken.
//
// PARAMETERS
//   DEPTH    4   number of entries; power of two, >= 2
//   ADDR_W   64  PC width
//   INSTR_W  32  instruction width
//
// PORTS
//   clk        in   1                   clock, all state on rising edge
//   reset      in   1                   asynchronous, active-low (0 = reset)
//   in_valid   in   1                   fetch presents a valid pair
//   in_ready   out  1                   queue accepts a pair this cycle
//   in_pc      in   ADDR_W              PC of the fetched instruction
//   in_instr   in   INSTR_W             fetched instruction word
//   out_valid  out  1                   head entry valid for decode
//   out_ready  in   1                   decode consumes head this cycle
//   out_pc     out  ADDR_W              PC of head entry
//   out_instr  out  INSTR_W             instruction of head entry
//   flush      in   1                   branch redirect; discard contents
//   count      out  $clog2(DEPTH+1)     number of occupied entries
//   full       out  1                   count == DEPTH
//   empty      out  1                   count == 0
//
// BEHAVIOUR
//   - Reset (reset==0, async): rd_ptr = wr_ptr = 0, count = 0, empty = 1,
//     full = 0, out_valid = 0, in_ready = 1, out_pc = 0, out_instr = 0.
//     Reset mid-operation drops all entries immediately. It does not wait
//     for a clock edge.
//   - Push: in_valid & in_ready at an edge. Writes entry[wr_ptr] and
//     increments wr_ptr modulo DEPTH.
//   - Pop: out_valid & out_ready at an edge. Increments rd_ptr modulo DEPTH.
//   - in_ready = !full. It is independent of out_ready, so there is no
//     combinational path from decode to fetch. When full, a pop and a push
//     cannot happen in the same cycle.
//   - out_valid = !empty. out_pc and out_instr are driven from entry[rd_ptr]
//     and are forced to 0 when empty.
//   - Latency: a pair pushed at edge N is visible on out_* after edge N
//     (cycle N+1). There is no same-cycle bypass.
//   - Push and pop in the same cycle (0 < count < DEPTH): count is
//     unchanged and both pointers advance.
//   - Pointers wrap modulo DEPTH. count is tracked explicitly, so full and
//     empty are never ambiguous.
//   - Flush (synchronous, highest priority): at the edge, rd_ptr = wr_ptr = 0
//     and count = 0. Any push or pop requested in that cycle is ignored. The
//     instruction on in_* during the flush cycle is dropped. It is wrong-path
//     fetch, and fetch re-presents the branch target on the next cycle.
//   - Entry storage is not cleared on flush or reset. Only pointers and
//     count are cleared.
//   - Order is strictly FIFO. Entries are never reordered or duplicated.
//
// TESTING
//   1. Reset: assert reset=0 mid-cycle with 2 entries queued
//      -> count=0, out_valid=0, out_pc=0, in_ready=1, without waiting for
//      a clock edge.
//   2. Fill: push pc=0x0,0x4,0x8,0xC with out_ready=0
//      -> full=1, in_ready=0, count=4. A 5th push (pc=0x10) is not accepted.
//      Then pop 4 -> out_pc sequence 0x0,0x4,0x8,0xC, then empty=1.
//   3. Streaming: in_valid=1 and out_ready=1 every cycle for 10 cycles,
//      pc incrementing by 4
//      -> count stays at 1 after the first cycle. out_pc lags in_pc by one
//      cycle. Pointers wrap at least twice.
//   4. Flush: 3 entries queued, flush=1 with in_valid=1 (pc=0x40) and
//      out_ready=1
//      -> after the edge count=0 and out_valid=0, 0x40 is not stored. Next
//      push pc=0x100 -> out_pc=0x100 one cycle later.
//   5. Full and simultaneous pop: full with out_ready=1 and in_valid=1
//      -> head is popped, no push, count=3. On the next cycle in_ready=1.
//   6. Random valid/ready with occasional flush, checked against a
//      reference queue model -> no loss, duplication or reordering between
//      flushes.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The queue takes the slave modport; the fetch/decode side takes the master modport.
interface fetch_queue_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               flush;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count, full, empty
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count, full, empty
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} queue between fetch and decode with synchronous flush.
// Status and head outputs are registered; the head is precomputed from next-state pointers.
module fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pcMem    [DEPTH];
    logic [INSTR_W-1:0] instrMem [DEPTH];

    logic [PTR_W-1:0]   rdPtr, wrPtr, rdPtrNext, wrPtrNext;
    logic [CNT_W-1:0]   countQ, countNext;
    logic               fullQ, emptyQ, inReadyQ, outValidQ;
    logic [ADDR_W-1:0]  headPc, headPcNext;
    logic [INSTR_W-1:0] headInstr, headInstrNext;
    logic               push, pop;

    // Next-state pointers, occupancy and head entry; flush overrides any handshake.
    always_comb begin
        push          = bus.in_valid  & ~fullQ  & ~bus.flush;
        pop           = bus.out_ready & ~emptyQ & ~bus.flush;
        rdPtrNext     = rdPtr;
        wrPtrNext     = wrPtr;
        countNext     = countQ;
        headPcNext    = '0;
        headInstrNext = '0;

        if (bus.flush) begin
            rdPtrNext = '0;
            wrPtrNext = '0;
            countNext = '0;
        end else begin
            if (push) wrPtrNext = wrPtr + PTR_W'(1);
            if (pop)  rdPtrNext = rdPtr + PTR_W'(1);
            if (push && !pop)      countNext = countQ + CNT_W'(1);
            else if (pop && !push) countNext = countQ - CNT_W'(1);
        end

        // New head is the word being written when the read pointer lands on the write slot.
        if (countNext != '0) begin
            if (push && (rdPtrNext == wrPtr)) begin
                headPcNext    = bus.in_pc;
                headInstrNext = bus.in_instr;
            end else begin
                headPcNext    = pcMem[rdPtrNext];
                headInstrNext = instrMem[rdPtrNext];
            end
        end
    end

    // Entry storage keeps its contents across flush and reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]    <= bus.in_pc;
            instrMem[wrPtr] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            countQ    <= '0;
            fullQ     <= 1'b0;
            emptyQ    <= 1'b1;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            headPc    <= '0;
            headInstr <= '0;
        end else begin
            rdPtr     <= rdPtrNext;
            wrPtr     <= wrPtrNext;
            countQ    <= countNext;
            fullQ     <= (countNext == CNT_W'(DEPTH));
            emptyQ    <= (countNext == '0);
            inReadyQ  <= (countNext != CNT_W'(DEPTH));
            outValidQ <= (countNext != '0);
            headPc    <= headPcNext;
            headInstr <= headInstrNext;
        end
    end

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = outValidQ;
    assign bus.out_pc    = headPc;
    assign bus.out_instr = headInstr;
    assign bus.count     = countQ;
    assign bus.full      = fullQ;
    assign bus.empty     = emptyQ;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a reference-queue scoreboard.
module tb_fetch_queue;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: queue of expected pairs
    logic [ADDR_W-1:0]  pcQ  [$];
    logic [INSTR_W-1:0] insQ [$];

    // DUT outputs sampled on the falling edge, consumed at the following rising edge
    logic               sValid, sReady;
    logic [ADDR_W-1:0]  sPc;
    logic [INSTR_W-1:0] sInstr;
    logic [2:0]         sCount;

    function automatic logic [INSTR_W-1:0] instrOf(input logic [ADDR_W-1:0] pc);
        logic [31:0] lo;
        lo = pc[31:0];
        return {lo[15:0], ~lo[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always @(negedge clk) begin
        sValid = bus.out_valid;
        sReady = bus.in_ready;
        sPc    = bus.out_pc;
        sInstr = bus.out_instr;
        sCount = bus.count;
    end

    // Scoreboard: expected entries pushed on accepted input, popped and compared on output
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcQ.delete();
            insQ.delete();
        end else begin
            checks++;
            if (sCount !== 3'(pcQ.size())) begin
                errors++;
                $display("FAIL mon_count: got %0d expected %0d", sCount, pcQ.size());
            end
            checks++;
            if (sReady !== (pcQ.size() < DEPTH)) begin
                errors++;
                $display("FAIL mon_in_ready: got %0b expected %0b", sReady, pcQ.size() < DEPTH);
            end
            if (pcQ.size() == 0) begin
                checks++;
                if (sValid !== 1'b0 || sPc !== '0 || sInstr !== '0) begin
                    errors++;
                    $display("FAIL mon_empty_head: got valid=%0b pc=%0h instr=%0h expected 0/0/0",
                             sValid, sPc, sInstr);
                end
            end
            if (bus.flush) begin
                pcQ.delete();
                insQ.delete();
            end else begin
                automatic bit doPush = bus.in_valid && (pcQ.size() < DEPTH);
                if (bus.out_ready && pcQ.size() > 0) begin
                    checks++;
                    if (sValid !== 1'b1 || sPc !== pcQ[0] || sInstr !== insQ[0]) begin
                        errors++;
                        $display("FAIL mon_pop: got valid=%0b pc=%0h instr=%0h expected 1 pc=%0h instr=%0h",
                                 sValid, sPc, sInstr, pcQ[0], insQ[0]);
                    end
                    void'(pcQ.pop_front());
                    void'(insQ.pop_front());
                end
                if (doPush) begin
                    pcQ.push_back(bus.in_pc);
                    insQ.push_back(bus.in_instr);
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [ADDR_W-1:0] pc, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = instrOf(pc);
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.in_ready !== 1'b1 || bus.out_pc !== '0 || bus.out_instr !== '0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d e=%0b f=%0b ov=%0b ir=%0b pc=%0h ins=%0h expected 0 1 0 0 1 0 0",
                     bus.count, bus.empty, bus.full, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_instr);
        end
        drive(1'b1, 64'h1000, 1'b0, 1'b0); tick();
        drive(1'b1, 64'h1004, 1'b0, 1'b0); tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 3'd2 || bus.out_pc !== 64'h1000) begin
            errors++;
            $display("FAIL reset_prefill: got cnt=%0d pc=%0h expected 2 1000", bus.count, bus.out_pc);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: got cnt=%0d ov=%0b pc=%0h ir=%0b expected 0 0 0 1",
                     bus.count, bus.out_valid, bus.out_pc, bus.in_ready);
        end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: got f=%0b ir=%0b cnt=%0d expected 1 0 4", bus.full, bus.in_ready, bus.count);
        end
        drive(1'b1, 64'h10, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.count !== 3'd4 || bus.out_pc !== 64'h0) begin
            errors++;
            $display("FAIL fill_reject: got cnt=%0d pc=%0h expected 4 0", bus.count, bus.out_pc);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            checks++;
            if (bus.out_pc !== 64'(4 * i) || bus.out_instr !== instrOf(64'(4 * i))) begin
                errors++;
                $display("FAIL fill_drain_%0d: got pc=%0h expected %0h", i, bus.out_pc, 4 * i);
            end
            tick();
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty: got e=%0b ov=%0b expected 1 0", bus.empty, bus.out_valid);
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h200 + 64'(4 * i), 1'b1, 1'b0);
            tick();
            checks++;
            if (bus.count !== 3'd1 || bus.out_pc !== 64'h200 + 64'(4 * i)) begin
                errors++;
                $display("FAIL stream_%0d: got cnt=%0d pc=%0h expected 1 %0h", i, bus.count, bus.out_pc, 'h200 + 4 * i);
            end
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL stream_empty: got e=%0b expected 1", bus.empty);
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h20 + 64'(4 * i), 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL flush_prefill: got cnt=%0d expected 3", bus.count);
        end
        drive(1'b1, 64'h40, 1'b1, 1'b1);
        tick();
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== '0) begin
            errors++;
            $display("FAIL flush_clear: got cnt=%0d ov=%0b pc=%0h expected 0 0 0", bus.count, bus.out_valid, bus.out_pc);
        end
        drive(1'b1, 64'h100, 1'b0, 1'b0);
        tick();
        checks++;
        if (bus.count !== 3'd1 || bus.out_pc !== 64'h100) begin
            errors++;
            $display("FAIL flush_target: got cnt=%0d pc=%0h expected 1 100", bus.count, bus.out_pc);
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h300 + 64'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h400, 1'b1, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_ready_before: got %0b expected 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.count !== 3'd3 || bus.in_ready !== 1'b1 || bus.out_pc !== 64'h304) begin
            errors++;
            $display("FAIL fullpop_after: got cnt=%0d ir=%0b pc=%0h expected 3 1 304", bus.count, bus.in_ready, bus.out_pc);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            tick();
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_drain: got e=%0b expected 1", bus.empty);
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] pc = 64'h8000;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            pc += 64'd4;
            tick();
            checks++;
            if (bus.count !== 3'(pcQ.size()) || bus.empty !== (pcQ.size() == 0) || bus.full !== (pcQ.size() == DEPTH)) begin
                errors++;
                $display("FAIL rand_%0d: got cnt=%0d e=%0b f=%0b expected %0d", i, bus.count, bus.empty, bus.full, pcQ.size());
            end
        end
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0);
            tick();
        end
        checks++;
        if (bus.empty !== 1'b1 || pcQ.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got e=%0b model=%0d expected 1 0", bus.empty, pcQ.size());
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #13 reset = 1'b1;
        tick();
        test_reset();
        test_fill();
        test_streaming();
        test_flush();
        test_full_pop();
        test_random();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
